// File: rtl/tdc_result_packer.sv
// TDC result packer: buffers measurement words in a FIFO and streams each one
// as a framed byte sequence (A5, seq, data MSB first, checksum) over valid/ready.
module tdc_result_packer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 16,
    parameter int NB         = 3
) (
    input  logic                          clk0,
    input  logic                          iRst,
    input  logic [DATA_W-1:0]             iTDC,
    input  logic                          iDone,
    output logic [7:0]                    oByte,
    output logic                          oValid,
    input  logic                          iReady,
    output logic                          oFull,
    output logic                          oEmpty,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel,
    output logic [7:0]                    oOverflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = NB * 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_SEQ  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_CSUM = 3'd4;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
    logic              push, pop, hs;

    logic [2:0]        state;
    logic [7:0]        seq, csum;
    logic [SW-1:0]     shreg;
    logic [IW-1:0]     idx;

    // Writes only consult the registered full flag, so a same-cycle pop never rescues them.
    assign push   = iDone & ~oFull;
    assign pop    = (state == S_IDLE) & ~oEmpty;
    assign hs     = oValid & iReady;
    assign oValid = (state != S_IDLE);
    assign oLevel = wr_ptr - rd_ptr;

    always_comb begin
        wr_nxt  = wr_ptr + {{AW{1'b0}}, push};
        rd_nxt  = rd_ptr + {{AW{1'b0}}, pop};
        lvl_nxt = wr_nxt - rd_nxt;
    end

    always_ff @(posedge clk0) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= iTDC;
        end
    end

    always_ff @(posedge clk0) begin
        if (iRst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            oFull     <= 1'b0;
            oEmpty    <= 1'b1;
            oOverflow <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            oFull  <= (lvl_nxt == (AW+1)'(FIFO_DEPTH));
            oEmpty <= (lvl_nxt == '0);
            if (iDone && oFull && (oOverflow != 8'hFF)) begin
                oOverflow <= oOverflow + 8'd1;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (iRst) begin
            state <= S_IDLE;
            seq   <= '0;
            csum  <= '0;
            shreg <= '0;
            idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg <= SW'(mem[rd_ptr[AW-1:0]]);
                        csum  <= seq;
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (hs) state <= S_SEQ;
                end
                S_SEQ: begin
                    if (hs) begin
                        idx   <= '0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        csum  <= csum ^ shreg[SW-1 -: 8];
                        shreg <= shreg << 8;
                        if (idx == IW'(NB - 1)) begin
                            state <= S_CSUM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_CSUM: begin
                    if (hs) begin
                        seq   <= seq + 8'd1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        oByte = 8'h00;
        case (state)
            S_HDR:   oByte = 8'hA5;
            S_SEQ:   oByte = seq;
            S_DATA:  oByte = shreg[SW-1 -: 8];
            S_CSUM:  oByte = csum;
            default: oByte = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tdc_result_packer.sv
// Randomized scoreboard bench for tdc_result_packer: expected frames are queued
// when words are issued and a negedge monitor checks every accepted byte.
module tb_tdc_result_packer;

    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 16;
    localparam int NB         = 3;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic              clk0 = 1'b0;
    logic              iRst;
    logic [DATA_W-1:0] iTDC;
    logic              iDone;
    logic [7:0]        oByte;
    logic              oValid;
    logic              iReady;
    logic              oFull;
    logic              oEmpty;
    logic [LW-1:0]     oLevel;
    logic [7:0]        oOverflow;

    tdc_result_packer #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH),
        .NB        (NB)
    ) dut (
        .clk0     (clk0),
        .iRst     (iRst),
        .iTDC     (iTDC),
        .iDone    (iDone),
        .oByte    (oByte),
        .oValid   (oValid),
        .iReady   (iReady),
        .oFull    (oFull),
        .oEmpty   (oEmpty),
        .oLevel   (oLevel),
        .oOverflow(oOverflow)
    );

    always #5 clk0 = ~clk0;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    int         model_seq = 0;
    int         hs_count  = 0;
    int         ready_mode = 0;   // 0: held by stimulus, 1: toggle, 2: random
    logic       prev_stall = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: header, sequence, word bytes MSB first, XOR of seq and data.
    task automatic push_frame(input logic [DATA_W-1:0] w);
        logic [7:0] b;
        logic [7:0] cs;
        longint     wl;
        wl = longint'(w);
        cs = 8'(model_seq);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(model_seq));
        for (int k = 0; k < NB; k++) begin
            b  = 8'((wl >> (8 * (NB - 1 - k))) & 255);
            cs = cs ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(cs);
        model_seq = (model_seq + 1) % 256;
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        iTDC  = w;
        iDone = 1'b1;
        push_frame(w);
        tick();
        iDone = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0 && !oValid) return;
            tick();
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: drain timeout, %0d bytes outstanding, oValid=%0b", name, exp_q.size(), oValid);
    endtask

    always @(posedge clk0) begin
        #1;
        if (ready_mode == 1) iReady = ~iReady;
        else if (ready_mode == 2) iReady = 1'($urandom_range(0, 1));
    end

    always @(negedge clk0) begin
        if (iRst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", oValid, 1);
                chk("hold_byte", oByte, prev_byte);
            end
            if (oValid && iReady) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_byte: got unexpected 0x%0h with nothing queued at %0t", oByte, $time);
                end else begin
                    chk("stream_byte", oByte, exp_q.pop_front());
                end
            end
            prev_stall = oValid && !iReady;
            prev_byte  = oByte;
        end
    end

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int found;
        logic [DATA_W-1:0] w;

        iRst = 1'b1; iTDC = '0; iDone = 1'b0; iReady = 1'b0;
        tick(); tick();
        chk("rst_valid", oValid, 0);
        chk("rst_byte", oByte, 8'h00);
        chk("rst_full", oFull, 0);
        chk("rst_empty", oEmpty, 1);
        chk("rst_level", oLevel, 0);
        chk("rst_overflow", oOverflow, 0);
        iRst = 1'b0;
        tick();

        // Single word with known checksum and header latency
        iReady = 1'b1;
        send_word(24'h123456);
        chk("lat_not_empty", oEmpty, 0);
        chk("lat_no_hdr_yet", oValid, 0);
        tick();
        chk("lat_hdr_valid", oValid, 1);
        chk("lat_hdr_byte", oByte, 8'hA5);
        drain("single");
        chk("single_empty", oEmpty, 1);
        chk("single_idle", oValid, 0);

        // Backpressure: toggling then random ready
        ready_mode = 1;
        send_word(24'h123456);
        for (int i = 0; i < 5; i++) send_word(DATA_W'($urandom));
        drain("toggle");
        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            send_word(DATA_W'($urandom));
            repeat ($urandom_range(0, 6)) tick();
        end
        drain("random_ready");

        // Burst overflow: the first word is claimed by the framer, the next 16 fill the FIFO
        ready_mode = 0;
        iReady = 1'b0;
        tick();
        for (int i = 1; i <= 20; i++) begin
            iTDC  = DATA_W'(i);
            iDone = 1'b1;
            if (i <= FIFO_DEPTH + 1) push_frame(DATA_W'(i));
            tick();
        end
        iDone = 1'b0;
        chk("burst_full", oFull, 1);
        chk("burst_level", oLevel, FIFO_DEPTH);
        chk("burst_overflow", oOverflow, 20 - (FIFO_DEPTH + 1));
        iReady = 1'b1;
        drain("burst");
        chk("burst_overflow_kept", oOverflow, 20 - (FIFO_DEPTH + 1));
        chk("burst_not_full", oFull, 0);

        // Reset during the data bytes of a frame with words queued behind it
        iReady = 1'b1;
        base = hs_count;
        for (int i = 0; i < 4; i++) send_word(DATA_W'($urandom));
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (hs_count >= base + 3) found = 1;
            else tick();
        end
        chk("midframe_reached", found, 1);
        iRst = 1'b1;
        exp_q.delete();
        model_seq = 0;
        tick();
        iRst = 1'b0;
        chk("midrst_valid", oValid, 0);
        chk("midrst_level", oLevel, 0);
        chk("midrst_overflow", oOverflow, 0);
        chk("midrst_empty", oEmpty, 1);
        send_word(DATA_W'($urandom));
        drain("post_reset");

        // Sequence wrap over 257 frames from a fresh reset
        iRst = 1'b1;
        exp_q.delete();
        model_seq = 0;
        tick();
        iRst = 1'b0;
        ready_mode = 2;
        for (int f = 0; f < 257; f++) begin
            for (int i = 0; i < 100 && oLevel >= LW'(FIFO_DEPTH - 2); i++) tick();
            send_word(DATA_W'($urandom));
        end
        drain("wrap");
        ready_mode = 0;

        // Push in the same cycle IDLE pops, with one word waiting
        iReady = 1'b0;
        tick();
        send_word(DATA_W'($urandom));
        tick();
        send_word(DATA_W'($urandom));
        chk("pp_level_before", oLevel, 1);
        iReady = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk0);
            if (!oValid && oLevel == LW'(1)) found = 1;
        end
        chk("pp_idle_seen", found, 1);
        w     = DATA_W'($urandom);
        iTDC  = w;
        iDone = 1'b1;
        push_frame(w);
        tick();
        iDone = 1'b0;
        chk("pp_level_after", oLevel, 1);
        chk("pp_overflow", oOverflow, 0);
        chk("pp_popped", oValid, 1);
        drain("push_pop");
        chk("final_empty", oEmpty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
